// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit for the 5-stage RISC-V core.
// Runs one load or store per request over a req/ack data-memory port. It
// steers store data onto byte lanes, generates byte enables, sign- or
// zero-extends load data, and flags misaligned half/word accesses. Stall
// holds the upstream stages while an access is outstanding.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   MemValid          load/store present in the memory stage
//   MemWrite          1 = store, 0 = load
//   MemSize           00 byte, 01 half, 10/11 word
//   MemUnsigned       loads: 1 = zero-extend, 0 = sign-extend
//   ALUResult         effective byte address
//   WriteData         right-aligned store data
//   ReadData          extended load result, valid while Done
//   Done              one-cycle completion pulse
//   Stall             combinational: MemValid & ~Done
//   MisalignedFault   one-cycle pulse alongside Done for a misaligned access
//   DMemReq/We/Addr/WData/BE   data-memory request (registered)
//   DMemAck, DMemRData         data-memory completion and read word
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemValid,
  input  logic                  MemWrite,
  input  logic [1:0]            MemSize,
  input  logic                  MemUnsigned,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Done,
  output logic                  Stall,
  output logic                  MisalignedFault,
  output logic                  DMemReq,
  output logic                  DMemWe,
  output logic [ADDR_WIDTH-1:0] DMemAddr,
  output logic [DATA_WIDTH-1:0] DMemWData,
  output logic [3:0]            DMemBE,
  input  logic                  DMemAck,
  input  logic [DATA_WIDTH-1:0] DMemRData
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

  state_t                state_q, state_d;

  // Registered copy of the request attributes needed when the ack arrives
  logic                  we_q, uns_q;
  logic [1:0]            size_q, lane_q;

  logic                  req_d, we_d, done_d, fault_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
  logic [3:0]            be_d;

  logic                  accept_c, misaligned_c;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] wdata_c, load_c;
  logic [BYTE_W-1:0]     byte_c;
  logic [HALF_W-1:0]     half_c;

  assign Stall    = MemValid & ~Done;
  assign accept_c = (state_q == IDLE) & MemValid;

  // Half needs addr[0]=0; word (and size 11) needs addr[1:0]=00
  assign misaligned_c = ((MemSize == 2'b01) & ALUResult[0]) |
                        (MemSize[1] & (|ALUResult[1:0]));

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = WriteData;
    case (MemSize)
      2'b00: begin
        be_c    = 4'b0001 << ALUResult[1:0];
        wdata_c = {4{WriteData[BYTE_W-1:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << ALUResult[1:0];
        wdata_c = {2{WriteData[HALF_W-1:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = WriteData;
      end
    endcase
  end

  // Lane extraction and extension of the returning read word
  always_comb begin
    byte_c = DMemRData[7:0];
    case (lane_q)
      2'd0:    byte_c = DMemRData[7:0];
      2'd1:    byte_c = DMemRData[15:8];
      2'd2:    byte_c = DMemRData[23:16];
      default: byte_c = DMemRData[31:24];
    endcase
    half_c = lane_q[1] ? DMemRData[31:16] : DMemRData[15:0];
    case (size_q)
      2'b00:   load_c = uns_q ? {24'd0, byte_c} : {{24{byte_c[BYTE_W-1]}}, byte_c};
      2'b01:   load_c = uns_q ? {16'd0, half_c} : {{16{half_c[HALF_W-1]}}, half_c};
      default: load_c = DMemRData;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    be_d    = 4'b0000;
    done_d  = 1'b0;
    fault_d = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (MemValid) begin
          if (misaligned_c) begin
            state_d = FAULT;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = MemWrite;
            addr_d  = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
            wdata_d = wdata_c;
            be_d    = be_c;
          end
        end
      end
      REQ: begin
        if (DMemAck) begin
          state_d = RESP;
          done_d  = 1'b1;
          rdata_d = we_q ? '0 : load_c;
        end else begin
          // Hold the request steady until the memory acknowledges
          req_d   = 1'b1;
          we_d    = DMemWe;
          addr_d  = DMemAddr;
          wdata_d = DMemWData;
          be_d    = DMemBE;
        end
      end
      RESP:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      DMemReq         <= 1'b0;
      DMemWe          <= 1'b0;
      DMemAddr        <= '0;
      DMemWData       <= '0;
      DMemBE          <= 4'b0000;
      Done            <= 1'b0;
      MisalignedFault <= 1'b0;
      ReadData        <= '0;
    end else begin
      state_q         <= state_d;
      DMemReq         <= req_d;
      DMemWe          <= we_d;
      DMemAddr        <= addr_d;
      DMemWData       <= wdata_d;
      DMemBE          <= be_d;
      Done            <= done_d;
      MisalignedFault <= fault_d;
      ReadData        <= rdata_d;
    end
  end

  // Request attributes captured at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
    end else if (accept_c) begin
      we_q   <= MemWrite;
      uns_q  <= MemUnsigned;
      size_q <= MemSize;
      lane_q <= ALUResult[1:0];
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// wait-state / spurious-ack / mid-access reset sequences, and randomized
// accesses checked against a behavioural model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemValid, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Done, Stall, MisalignedFault;
  logic        DMemReq, DMemWe;
  logic [31:0] DMemAddr, DMemWData;
  logic [3:0]  DMemBE;
  logic        DMemAck;
  logic [31:0] DMemRData;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_id   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemValid(MemValid), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Done(Done), .Stall(Stall),
    .MisalignedFault(MisalignedFault),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr),
    .DMemWData(DMemWData), .DMemBE(DMemBE),
    .DMemAck(DMemAck), .DMemRData(DMemRData)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          waits;
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h expected %h", cur_id, name, act, exp);
    end
  endtask

  // Behavioural model: expected results from the access rules in plain arithmetic
  function automatic vec_t model(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] mem, input int waits);
    vec_t v;
    int unsigned a, width_bytes, field;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
    v.mem = mem; v.waits = waits;
    a = addr % 4;
    width_bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v.exp_fault = (addr % width_bytes) != 0;
    v.exp_addr  = addr - a;
    if (width_bytes == 4) begin
      v.exp_be    = 4'hF;
      v.exp_wdata = wd;
    end else if (width_bytes == 2) begin
      v.exp_be    = 4'((3 << a) % 16);
      v.exp_wdata = (wd % 65536) * 32'h0001_0001;
    end else begin
      v.exp_be    = 4'(1 << a);
      v.exp_wdata = (wd % 256) * 32'h0101_0101;
    end
    if (we || v.exp_fault) v.exp_rdata = 32'd0;
    else if (width_bytes == 4) v.exp_rdata = mem;
    else begin
      field = (mem >> (8 * (a - a % width_bytes))) % (1 << (8 * width_bytes));
      if (!uns && field >= (1 << (8 * width_bytes - 1)))
        v.exp_rdata = field - (1 << (8 * width_bytes));
      else
        v.exp_rdata = field;
    end
    return v;
  endfunction

  // Drives one access from IDLE (entered at #1 after a posedge) and checks it cycle by cycle
  task automatic run_vec(input vec_t v);
    MemValid = 1'b1; MemWrite = v.we; MemSize = v.sz; MemUnsigned = v.uns;
    ALUResult = v.addr; WriteData = v.wdata; DMemAck = 1'b0; DMemRData = $urandom;
    @(negedge clk);
    chk("stall_c0", 32'(Stall), 32'd1);
    chk("req_c0", 32'(DMemReq), 32'd0);
    chk("done_c0", 32'(Done), 32'd0);
    @(posedge clk); #1;
    if (v.exp_fault) begin
      @(negedge clk);
      chk("fault_req", 32'(DMemReq), 32'd0);
      chk("fault_done", 32'(Done), 32'd1);
      chk("fault_flag", 32'(MisalignedFault), 32'd1);
      chk("fault_rdata", ReadData, 32'd0);
    end else begin
      for (int i = 0; i <= v.waits; i++) begin
        if (i == v.waits) begin
          DMemAck = 1'b1; DMemRData = v.mem;
        end
        @(negedge clk);
        chk("req", 32'(DMemReq), 32'd1);
        chk("we", 32'(DMemWe), 32'(v.we));
        chk("addr", DMemAddr, v.exp_addr);
        chk("be", 32'(DMemBE), 32'(v.exp_be));
        chk("wdata", DMemWData, v.exp_wdata);
        chk("done_wait", 32'(Done), 32'd0);
        chk("stall_wait", 32'(Stall), 32'd1);
        @(posedge clk); #1;
      end
      DMemAck = 1'b0; DMemRData = $urandom;
      @(negedge clk);
      chk("done", 32'(Done), 32'd1);
      chk("nofault", 32'(MisalignedFault), 32'd0);
      chk("rdata", ReadData, v.exp_rdata);
      chk("req_off", 32'(DMemReq), 32'd0);
      chk("stall_done", 32'(Stall), 32'd0);
    end
    @(posedge clk); #1;
    MemValid = 1'b0;
    chk("done_pulse", 32'(Done), 32'd0);
  endtask

  vec_t tbl[10];

  initial begin
    // we sz uns addr wdata mem waits | fault addr be wdata rdata
    tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0,
               1'b0, 32'h1000_0004, 4'hF, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'h80FF_7F01, 0,
               1'b0, 32'h20, 4'h8, 32'h0, 32'hFFFF_FF80};
    tbl[2] = '{1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 32'h80FF_7F01, 1,
               1'b0, 32'h20, 4'h8, 32'h0, 32'h0000_0080};
    tbl[3] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234_ABCD, 32'h0, 0,
               1'b0, 32'h10, 4'hC, 32'hABCD_ABCD, 32'h0};
    tbl[4] = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h8001_0000, 0,
               1'b0, 32'h10, 4'hC, 32'h0, 32'hFFFF_8001};
    tbl[5] = '{1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 0,
               1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    tbl[6] = '{1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 5,
               1'b0, 32'h40, 4'hF, 32'h0, 32'h1234_5678};
    tbl[7] = '{1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 32'hA5A5_A5A5, 0,
               1'b0, 32'h8, 4'hF, 32'h0, 32'hA5A5_A5A5};
    tbl[8] = '{1'b1, 2'd1, 1'b0, 32'h13, 32'h5555, 32'h0, 0,
               1'b1, 32'h0, 4'h0, 32'h0, 32'h0};
    tbl[9] = '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h1234_F00D, 2,
               1'b0, 32'h10, 4'h3, 32'h0, 32'h0000_F00D};

    rst_n = 1'b0; MemValid = 1'b0; MemWrite = 1'b0; MemSize = 2'd0;
    MemUnsigned = 1'b0; ALUResult = '0; WriteData = '0; DMemAck = 1'b0; DMemRData = '0;
    #12;
    chk("rst_req", 32'(DMemReq), 32'd0);
    chk("rst_we", 32'(DMemWe), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_fault", 32'(MisalignedFault), 32'd0);
    chk("rst_stall", 32'(Stall), 32'd0);
    chk("rst_addr", DMemAddr, 32'd0);
    chk("rst_wdata", DMemWData, 32'd0);
    chk("rst_rdata", ReadData, 32'd0);
    chk("rst_be", 32'(DMemBE), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      cur_id = i;
      run_vec(tbl[i]);
    end

    // Spurious ack while idle must be ignored
    cur_id = 100;
    DMemAck = 1'b1; DMemRData = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_req", 32'(DMemReq), 32'd0);
      chk("spur_done", 32'(Done), 32'd0);
      chk("spur_rdata", ReadData, 32'd0);
      @(posedge clk); #1;
    end
    DMemAck = 1'b0;
    cur_id = 101;
    run_vec(tbl[4]);

    // Reset asserted while the request is outstanding
    cur_id = 200;
    MemValid = 1'b1; MemWrite = 1'b1; MemSize = 2'd2; MemUnsigned = 1'b0;
    ALUResult = 32'h0000_0100; WriteData = 32'hCAFE_F00D; DMemAck = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(DMemReq), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; MemValid = 1'b0;
    #1;
    chk("mid_rst_req", 32'(DMemReq), 32'd0);
    chk("mid_rst_addr", DMemAddr, 32'd0);
    chk("mid_rst_be", 32'(DMemBE), 32'd0);
    chk("mid_rst_wdata", DMemWData, 32'd0);
    chk("mid_rst_we", 32'(DMemWe), 32'd0);
    chk("mid_rst_stall", 32'(Stall), 32'd0);
    DMemAck = 1'b1;
    @(negedge clk);
    DMemAck = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 32'(Done), 32'd0);
    @(posedge clk); #1;
    cur_id = 201;
    run_vec(tbl[0]);

    // Randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      cur_id = 1000 + i;
      a = $urandom;
      run_vec(model(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), a, $urandom, $urandom,
                    int'($urandom_range(0, 3))));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
